// File: rtl/helix_pkg.sv
// Shared types and constants for the helix die / environment loop.
// The responder entry layout and head-of-queue state live here so benches can reuse them.
package helix_pkg;

   localparam int ACTION_W   = 16;
   localparam int RESP_DEPTH = 4;
   localparam int RESP_LAT_W = 8;

   typedef struct packed {
      logic [ACTION_W-1:0]   data;
      logic [RESP_LAT_W-1:0] age;
   } resp_entry_t;

   // HEAD_OFFER means the head has been shown to the die and must stay put until taken
   typedef enum logic {
      HEAD_WAIT,
      HEAD_OFFER
   } head_state_e;

endpackage

// File: rtl/helix_resp_fifo.sv
// Circular store of in-flight actions for the world responder.
// Each live entry carries a saturating age counter that starts at zero when written.
module helix_resp_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int LAT_W  = 8,
   localparam int PW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              flush,
   output logic [DATA_W-1:0] head_data,
   output logic [LAT_W-1:0]  head_age,
   output logic              full,
   output logic              empty,
   output logic [PW-1:0]     occupancy
);

   localparam int IW = PW - 1;

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     count;
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [LAT_W-1:0]  age_mem  [DEPTH];
   logic [DEPTH-1:0]  live;

   // The extra pointer MSB makes the difference equal DEPTH when full and zero when empty
   assign count     = wr_ptr - rd_ptr;
   assign full      = (count == PW'(DEPTH));
   assign empty     = (count == '0);
   assign occupancy = count;
   assign head_data = data_mem[rd_ptr[IW-1:0]];
   assign head_age  = age_mem[rd_ptr[IW-1:0]];

   always_comb begin
      live = '0;
      for (int i = 0; i < DEPTH; i++) begin
         live[i] = ({1'b0, IW'(i) - rd_ptr[IW-1:0]} < count);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            age_mem[i] <= '0;
         end
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // Every live entry ages in parallel so a burst of actions is released as a burst
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (IW'(i) == wr_ptr[IW-1:0])) begin
               age_mem[i] <= '0;
            end else if (live[i] && (age_mem[i] != '1)) begin
               age_mem[i] <= age_mem[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr[IW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/helix_world_responder.sv
// Closed-loop environment model: accepts die actions, delays them by cfg_latency cycles
// and returns them offset by cfg_offset as world feedback.
module helix_world_responder #(
   parameter int ACTION_W = helix_pkg::ACTION_W,
   parameter int DEPTH    = helix_pkg::RESP_DEPTH,
   parameter int LAT_W    = helix_pkg::RESP_LAT_W,
   parameter int CNT_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       action_valid,
   output logic                       action_ready,
   input  logic [ACTION_W-1:0]        action_data,
   output logic                       world_valid,
   input  logic                       world_ready,
   output logic [ACTION_W-1:0]        world_data,
   input  logic [LAT_W-1:0]           cfg_latency,
   input  logic [ACTION_W-1:0]        cfg_offset,
   input  logic                       cfg_flush,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [CNT_W-1:0]           resp_count
);

   import helix_pkg::*;

   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic                push;
   logic                pop;
   logic                full;
   logic                empty;
   logic                offer;
   logic [ACTION_W-1:0] head_data;
   logic [LAT_W-1:0]    head_age;
   logic [OCC_W-1:0]    fifo_occ;
   head_state_e         state;
   head_state_e         state_next;

   helix_resp_fifo #(
      .DATA_W (ACTION_W),
      .DEPTH  (DEPTH),
      .LAT_W  (LAT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (action_data),
      .pop       (pop),
      .flush     (cfg_flush),
      .head_data (head_data),
      .head_age  (head_age),
      .full      (full),
      .empty     (empty),
      .occupancy (fifo_occ)
   );

   // No pass-through when full: a same-cycle pop does not open a slot for this cycle's action
   assign action_ready = !rst && !full && !cfg_flush;
   assign push         = action_valid && action_ready;

   // Once offered, the head stays valid regardless of later cfg_latency changes
   assign offer       = !rst && !empty && !cfg_flush &&
                        ((head_age >= cfg_latency) || (state == HEAD_OFFER));
   assign pop         = offer && world_ready;
   assign world_valid = offer;
   assign world_data  = offer ? (head_data + cfg_offset) : '0;
   assign occupancy   = rst ? '0 : fifo_occ;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HEAD_WAIT;
      end else begin
         state <= state_next;
      end
   end

   // After a pop the next head is judged combinationally, so it can be offered the same cycle
   always_comb begin
      state_next = HEAD_WAIT;
      if (offer && !world_ready) begin
         state_next = HEAD_OFFER;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_count <= '0;
      end else if (pop) begin
         resp_count <= resp_count + 1'b1;
      end
   end

endmodule
